vreg_element_sequencer: RTL
===========================

// Module: vreg_element_sequencer
// PURPOSE
//  Element sequencer for one 64x64 vector register (a true dual-port RAM instance).
//  Streams functional-unit results into the RAM through port A, and streams operands out through port B.
//  Port B output goes to a consumer via valid/ready, over a 2-entry skid buffer.
//  A read may chain behind an in-progress write: element i is read only after it has been written.
// PARAMETERS
//  DATA  64  element width, bits
//  ADDR  6   element address width; register holds 2**ADDR elements
// PORTS
//  clk            in   1       clock; all state on rising edge
//  rst_n          in   1       async active-low reset
//  wr_start       in   1       1-cycle pulse: begin write stream
//  wr_vl          in   ADDR+1  write length, sampled with wr_start
//  wr_elem_valid  in   1       element present on wr_elem_data
//  wr_elem_data   in   DATA    result element
//  wr_busy        out  1       write stream active
//  wr_done        out  1       1-cycle pulse after last element written
//  rd_start       in   1       1-cycle pulse: begin read stream
//  rd_vl          in   ADDR+1  read length, sampled with rd_start
//  rd_elem_valid  out  1       operand valid
//  rd_elem_data   out  DATA    operand element
//  rd_elem_ready  in   1       consumer accepts operand
//  rd_busy        out  1       read stream active (RUN or DRAIN)
//  rd_done        out  1       1-cycle pulse when last operand is accepted
//  ram_a_wr       out  1       RAM port A write enable
//  ram_a_addr     out  ADDR    RAM port A address
//  ram_a_din      out  DATA    RAM port A write data
//  ram_b_addr     out  ADDR    RAM port B address; RAM port B write enable is tied 0 at top level
//  ram_b_dout     in   DATA    RAM port B read data, valid 1 cycle after address
// BEHAVIOUR
//  Reset: all outputs 0, both FSMs IDLE, counters 0, skid empty. RAM contents are untouched.
//  Reset mid-stream: the stream is abandoned. No done pulse. Elements already written stay in RAM.
//  Length rule: vl=0 means no elements. The FSM stays IDLE and the done pulse fires 1 cycle after start.
//    vl > 2**ADDR is clamped to 2**ADDR.
//  Write FSM:
//    IDLE --wr_start--> RUN; wr_idx=0.
//    In RUN, each wr_elem_valid cycle:
//      - ram_a_wr=1, ram_a_addr=wr_idx, ram_a_din=wr_elem_data (combinational);
//      - wr_idx increments;
//      - on index vl-1 -> IDLE, wr_done the next cycle.
//    There is no write backpressure. wr_elem_valid in IDLE is ignored (ram_a_wr stays 0).
//    wr_start while wr_busy is ignored.
//  Read FSM: IDLE --rd_start--> RUN --last address issued--> DRAIN --skid empty and in-flight 0--> IDLE.
//    rd_start while rd_busy is ignored.
//    Chain flag: set at rd_start if wr_busy is 1 or wr_start is coincident. It clears when the write stream ends.
//    Issue of rd_idx in RUN requires all of:
//      - (chain flag clear) or (rd_idx < wr_idx as registered at the start of the cycle).
//        A same-cycle A/B address collision is never issued.
//      - skid occupancy + in-flight - (pop this cycle) < 2.
//    On issue: ram_b_addr=rd_idx, and the in-flight bit is set. The next cycle, ram_b_dout is pushed into the skid.
//  Skid buffer: 2-entry FIFO. rd_elem_valid = not empty; rd_elem_data = head.
//    A pop occurs on rd_elem_valid & rd_elem_ready.
//    rd_elem_data must hold stable while valid and not ready.
//  Latency: with ready held 1 and no chaining, rd_start at edge 0 gives rd_elem_valid after edge 2.
//    Thereafter 1 element per cycle.
//  rd_done: asserted in the cycle the last element pops; the FSM is IDLE after that edge.
//  Counters are ADDR+1 bits; no wrap (max index 2**ADDR-1).
//  Simultaneous wr_start and rd_start from IDLE: both streams start and the read is chained. This is the normal chained case.
// TESTING
//  1. Reset mid-stream: assert rst_n=0 mid write and mid read.
//     -> All outputs 0 asynchronously; no done pulses; the next start behaves normally.
//  2. Write vl=64, data i*3, valid every cycle; then read vl=64 with ready=1.
//     -> Write side: ram_a_addr 0..63, wr_done one cycle after the last element.
//     -> Read side: first valid 2 cycles after rd_start, 64 operands on consecutive cycles with data i*3, rd_done on element 63.
//  3. Read vl=10; ready toggles 1,0,0,1 repeating.
//     -> No loss or duplication, data stable while stalled, skid never exceeds 2.
//  4. Chaining: wr_start and rd_start the same cycle, vl=8; wr_elem_valid every 3rd cycle.
//     -> ram_b_addr never equals or exceeds wr_idx; 8 correct operands; rd_done after wr_done.
//  5. Edge lengths.
//     -> vl=0: done pulse next cycle and no RAM access.
//     -> vl=1: a single element.
//     -> vl=100: clamped to 64.
//  6. Protocol violations: wr_start while busy; wr_elem_valid while IDLE.
//     -> Both ignored; RAM unchanged.

Source files
------------

// File: rtl/vreg_element_sequencer.sv
// Element sequencer for one vector register: streams writes into RAM port A,
// streams reads out of port B through a 2-entry skid, optionally chained behind a write.
module vreg_element_sequencer #(
  parameter int DATA = 64,
  parameter int ADDR = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_start,
  input  logic [ADDR:0]   wr_vl,
  input  logic            wr_elem_valid,
  input  logic [DATA-1:0] wr_elem_data,
  output logic            wr_busy,
  output logic            wr_done,
  input  logic            rd_start,
  input  logic [ADDR:0]   rd_vl,
  output logic            rd_elem_valid,
  output logic [DATA-1:0] rd_elem_data,
  input  logic            rd_elem_ready,
  output logic            rd_busy,
  output logic            rd_done,
  output logic            ram_a_wr,
  output logic [ADDR-1:0] ram_a_addr,
  output logic [DATA-1:0] ram_a_din,
  output logic [ADDR-1:0] ram_b_addr,
  input  logic [DATA-1:0] ram_b_dout
);

  localparam logic [ADDR:0] MAXVL = {1'b1, {ADDR{1'b0}}};

  typedef enum logic {W_IDLE, W_RUN} wr_st_t;
  typedef enum logic [1:0] {R_IDLE, R_RUN, R_DRAIN} rd_st_t;

  wr_st_t        wr_st;
  rd_st_t        rd_st;
  logic [ADDR:0] wr_len, wr_idx;
  logic [ADDR:0] rd_len, rd_idx;
  logic [ADDR:0] wr_vl_c, rd_vl_c;
  logic          wr_last, wr_end, wr_go;
  logic          chain, inflight, rd_zero;
  logic          issue, room, pop, last_pop, rd_last_iss;
  logic [DATA-1:0] skid [2];
  logic          hd, tl;
  logic [1:0]    cnt;

  assign wr_vl_c = (wr_vl > MAXVL) ? MAXVL : wr_vl;
  assign rd_vl_c = (rd_vl > MAXVL) ? MAXVL : rd_vl;

  assign wr_busy    = (wr_st == W_RUN);
  assign ram_a_wr   = wr_busy & wr_elem_valid;
  assign ram_a_addr = wr_idx[ADDR-1:0];
  assign ram_a_din  = ram_a_wr ? wr_elem_data : '0;

  assign wr_last = (wr_idx == wr_len - 1'b1);
  assign wr_end  = ram_a_wr & wr_last;
  assign wr_go   = (wr_st == W_IDLE) & wr_start & (wr_vl_c != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_st   <= W_IDLE;
      wr_len  <= '0;
      wr_idx  <= '0;
      wr_done <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      unique case (wr_st)
        W_IDLE: begin
          if (wr_start) begin
            if (wr_vl_c == '0) begin
              wr_done <= 1'b1;
            end else begin
              wr_st  <= W_RUN;
              wr_idx <= '0;
              wr_len <= wr_vl_c;
            end
          end
        end
        W_RUN: begin
          if (wr_elem_valid) begin
            wr_idx <= wr_idx + 1'b1;
            if (wr_last) begin
              wr_st   <= W_IDLE;
              wr_done <= 1'b1;
            end
          end
        end
        default: wr_st <= W_IDLE;
      endcase
    end
  end

  assign rd_busy       = (rd_st != R_IDLE);
  assign rd_elem_valid = (cnt != 2'd0);
  assign rd_elem_data  = skid[hd];
  assign pop           = rd_elem_valid & rd_elem_ready;

  // Occupancy after this cycle's pop, counting the read already in flight.
  assign room = ({1'b0, cnt} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});

  // wr_idx is the next address to be written, so rd_idx < wr_idx
  // also rules out a same-cycle A/B collision.
  assign issue = (rd_st == R_RUN) & (~chain | (rd_idx < wr_idx)) & room;

  assign rd_last_iss = (rd_idx == rd_len - 1'b1);
  assign last_pop    = (rd_st == R_DRAIN) & ~inflight & (cnt == 2'd1) & pop;
  assign rd_done     = rd_zero | last_pop;
  assign ram_b_addr  = issue ? rd_idx[ADDR-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_st    <= R_IDLE;
      rd_len   <= '0;
      rd_idx   <= '0;
      chain    <= 1'b0;
      inflight <= 1'b0;
      rd_zero  <= 1'b0;
    end else begin
      rd_zero  <= 1'b0;
      inflight <= issue;
      if (wr_end) chain <= 1'b0;
      unique case (rd_st)
        R_IDLE: begin
          if (rd_start) begin
            if (rd_vl_c == '0) begin
              rd_zero <= 1'b1;
            end else begin
              rd_st  <= R_RUN;
              rd_idx <= '0;
              rd_len <= rd_vl_c;
              chain  <= (wr_busy & ~wr_end) | wr_go;
            end
          end
        end
        R_RUN: begin
          if (issue) begin
            rd_idx <= rd_idx + 1'b1;
            if (rd_last_iss) rd_st <= R_DRAIN;
          end
        end
        R_DRAIN: begin
          if (last_pop) rd_st <= R_IDLE;
        end
        default: rd_st <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid[0] <= '0;
      skid[1] <= '0;
      hd      <= 1'b0;
      tl      <= 1'b0;
      cnt     <= 2'd0;
    end else begin
      if (inflight) begin
        skid[tl] <= ram_b_dout;
        tl       <= ~tl;
      end
      if (pop) hd <= ~hd;
      cnt <= cnt + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule
